// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg : opcodes, functs, ALU op enum and reset PC for the MIPS core. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_regfile.sv
// ----------------------------------------------------------------------------
// mips_regfile : 32x32 register file, 2 async reads, 1 sync write, R0 = 0. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mips_regfile
  import mips_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0][31:0] regs_q;
  logic [31:0][31:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we && (wa != 5'd0)) begin
      regs_d[wa] = wd;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'h0 : regs_q[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'h0 : regs_q[ra2];

endmodule

`default_nettype wire

// File: rtl/mips_main.sv
// ----------------------------------------------------------------------------
// mips_main : single-cycle MIPS core (optional bne via MIPS_BNE_EN). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mips_main
  import mips_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mrd_i,
  output logic [31:0] mwd_i,
  output logic [31:0] mra_i,
  output logic [31:0] mwa_i,
  output logic        mwr_i,
  input  logic [31:0] mrd_d,
  output logic [31:0] mwd_d,
  output logic [31:0] mra_d,
  output logic [31:0] mwa_d,
  output logic        mwr_d
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] imm_sext;

  logic        reg_we;
  logic        wsel_rt;
  logic        use_imm;
  logic        mem_to_reg;
  logic        store;
  logic        br_eq;
  logic        br_ne;
  logic        jump;
  alu_op_e     alu_op;

  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        take_branch;

  assign op       = mrd_i[31:26];
  assign rs       = mrd_i[25:21];
  assign rt       = mrd_i[20:16];
  assign rd       = mrd_i[15:11];
  assign funct    = mrd_i[5:0];
  assign imm      = mrd_i[15:0];
  assign target   = mrd_i[25:0];
  assign imm_sext = sext16(imm);

  // Anything not matched below stays a NOP: no write, no store, sequential PC.
  always_comb begin
    reg_we     = 1'b0;
    wsel_rt    = 1'b0;
    use_imm    = 1'b0;
    mem_to_reg = 1'b0;
    store      = 1'b0;
    br_eq      = 1'b0;
    br_ne      = 1'b0;
    jump       = 1'b0;
    alu_op     = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin reg_we = 1'b1; alu_op = ALU_ADD; end
          FN_SUB: begin reg_we = 1'b1; alu_op = ALU_SUB; end
          FN_AND: begin reg_we = 1'b1; alu_op = ALU_AND; end
          FN_OR:  begin reg_we = 1'b1; alu_op = ALU_OR;  end
          FN_SLT: begin reg_we = 1'b1; alu_op = ALU_SLT; end
          default: ;
        endcase
      end
      OP_ADDI: begin
        reg_we  = 1'b1;
        wsel_rt = 1'b1;
        use_imm = 1'b1;
      end
      OP_LW: begin
        reg_we     = 1'b1;
        wsel_rt    = 1'b1;
        use_imm    = 1'b1;
        mem_to_reg = 1'b1;
      end
      OP_SW: begin
        use_imm = 1'b1;
        store   = 1'b1;
      end
      OP_BEQ: br_eq = 1'b1;
`ifdef MIPS_BNE_EN
      OP_BNE: br_ne = 1'b1;
`endif
      OP_J:   jump = 1'b1;
      default: ;
    endcase
  end

  mips_regfile u_regfile (
    .clock (clock),
    .reset (reset),
    .ra1   (rs),
    .ra2   (rt),
    .wa    (wb_addr),
    .we    (reg_we),
    .wd    (wb_data),
    .rd1   (rs_val),
    .rd2   (rt_val)
  );

  assign alu_b = use_imm ? imm_sext : rt_val;

  always_comb begin
    alu_y = 32'h0;
    case (alu_op)
      ALU_ADD: alu_y = rs_val + alu_b;
      ALU_SUB: alu_y = rs_val - alu_b;
      ALU_AND: alu_y = rs_val & alu_b;
      ALU_OR:  alu_y = rs_val | alu_b;
      ALU_SLT: alu_y = {31'h0, $signed(rs_val) < $signed(alu_b)};
      default: alu_y = 32'h0;
    endcase
  end

  assign wb_addr = wsel_rt ? rt : rd;
  assign wb_data = mem_to_reg ? mrd_d : alu_y;

  assign pc_plus4    = pc_q + 32'd4;
  assign take_branch = (br_eq && (rs_val == rt_val)) || (br_ne && (rs_val != rt_val));

  always_comb begin
    pc_d = pc_plus4;
    if (jump) begin
      pc_d = {pc_plus4[31:28], target, 2'b00};
    end else if (take_branch) begin
      pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign mra_i = pc_q;
  assign mwd_i = 32'h0;
  assign mwa_i = 32'h0;
  assign mwr_i = 1'b0;

  // Gating with reset keeps a store from committing if reset lands mid-sw.
  assign mwr_d = store & ~reset;
  assign mra_d = alu_y;
  assign mwa_d = alu_y;
  assign mwd_d = rt_val;

endmodule

`default_nettype wire

// File: tb/tb_mips_main.sv
// ----------------------------------------------------------------------------
// tb_mips_main : scoreboard bench for mips_main with behavioural memories. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mips_main;

  logic        clock;
  logic        reset;
  logic [31:0] mrd_i;
  logic [31:0] mwd_i;
  logic [31:0] mra_i;
  logic [31:0] mwa_i;
  logic        mwr_i;
  logic [31:0] mrd_d;
  logic [31:0] mwd_d;
  logic [31:0] mra_d;
  logic [31:0] mwa_d;
  logic        mwr_d;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  logic        dmem_clr;
  logic [31:0] exp_pc_q [$];
  st_t         exp_st_q [$];
  int          total;
  int          bad;

  mips_main dut (
    .clock (clock),
    .reset (reset),
    .mrd_i (mrd_i),
    .mwd_i (mwd_i),
    .mra_i (mra_i),
    .mwa_i (mwa_i),
    .mwr_i (mwr_i),
    .mrd_d (mrd_d),
    .mwd_d (mwd_d),
    .mra_d (mra_d),
    .mwa_d (mwa_d),
    .mwr_d (mwr_d)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign mrd_i = imem[mra_i[7:2]];
  assign mrd_d = dmem[mra_d[7:2]];

  always @(posedge clock) begin
    if (dmem_clr) begin
      for (int k = 0; k < 64; k++) dmem[k] <= 32'hDEAD_BEEF;
    end else if (mwr_d === 1'b1) begin
      dmem[mwa_d[7:2]] <= mwd_d;
    end
  end

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  task automatic push_st(input logic [31:0] a, input logic [31:0] d);
    st_t s;
    s.addr = a;
    s.data = d;
    exp_st_q.push_back(s);
  endtask

  // Hold reset for two cycles (also presets data memory), then release at a negedge.
  task automatic start_program();
    reset    = 1'b1;
    dmem_clr = 1'b1;
    @(negedge clock);
    @(negedge clock);
    dmem_clr = 1'b0;
    reset    = 1'b0;
    #1;
  endtask

  task automatic clear_imem();
    for (int k = 0; k < 64; k++) imem[k] = 32'h0;
  endtask

  // Run n instructions, scoring fetch PCs and every store against the queues.
  task automatic step_program(input int n, input string tag);
    logic [31:0] ep;
    st_t         es;
    for (int i = 0; i < n; i++) begin
      if (exp_pc_q.size() > 0) begin
        ep = exp_pc_q.pop_front();
        total++;
        if (mra_i !== ep) begin
          bad++;
          $display("FAIL %s pc step %0d: got %h want %h", tag, i, mra_i, ep);
        end
      end
      if (mwr_d !== 1'b0) begin
        total++;
        if (exp_st_q.size() == 0) begin
          bad++;
          $display("FAIL %s unexpected store step %0d: addr %h data %h", tag, i, mwa_d, mwd_d);
        end else begin
          es = exp_st_q.pop_front();
          if (mwa_d !== es.addr || mwd_d !== es.data || mra_d !== es.addr) begin
            bad++;
            $display("FAIL %s store step %0d: got %h/%h want %h/%h", tag, i, mwa_d, mwd_d,
                     es.addr, es.data);
          end
        end
      end
      @(negedge clock);
      #1;
    end
    total++;
    if (exp_pc_q.size() != 0 || exp_st_q.size() != 0) begin
      bad++;
      $display("FAIL %s leftover: pcs %0d stores %0d want 0 0", tag, exp_pc_q.size(),
               exp_st_q.size());
      exp_pc_q.delete();
      exp_st_q.delete();
    end
  endtask

  task automatic test_reset();
    clear_imem();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'h0055);
    imem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h000C);
    reset    = 1'b1;
    dmem_clr = 1'b1;
    #1;
    total++;
    if (mra_i !== 32'h0 || mwr_d !== 1'b0 || mwr_i !== 1'b0 || mwd_i !== 32'h0 || mwa_i !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: mra_i %h mwr_d %b mwr_i %b mwd_i %h mwa_i %h want all 0",
               mra_i, mwr_d, mwr_i, mwd_i, mwa_i);
    end
    start_program();
    exp_pc_q.push_back(32'h0);
    step_program(1, "reset_pre");
    total++;
    if (mwr_d !== 1'b1 || mra_i !== 32'h4) begin
      bad++;
      $display("FAIL reset_sw_cycle: mwr_d %b pc %h want 1 00000004", mwr_d, mra_i);
    end
    reset = 1'b1;
    #1;
    total++;
    if (mra_i !== 32'h0 || mwr_d !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: mra_i %h mwr_d %b want 0 0", mra_i, mwr_d);
    end
    @(posedge clock);
    #1;
    total++;
    if (dmem[3] !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL reset_no_store: mem %h want deadbeef", dmem[3]);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    exp_pc_q.push_back(32'h0);
    exp_pc_q.push_back(32'h4);
    push_st(32'hC, 32'h55);
    step_program(2, "reset_post");
  endtask

  task automatic test_arith();
    clear_imem();
    imem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    imem[2]  = enc_r(6'h20, 5'd1, 5'd2, 5'd3);
    imem[3]  = enc_r(6'h22, 5'd2, 5'd1, 5'd4);
    imem[4]  = enc_r(6'h2A, 5'd2, 5'd1, 5'd5);
    imem[5]  = enc_r(6'h24, 5'd1, 5'd2, 5'd7);
    imem[6]  = enc_r(6'h25, 5'd1, 5'd2, 5'd8);
    imem[7]  = enc_i(6'h2B, 5'd0, 5'd3, 16'd0);
    imem[8]  = enc_i(6'h2B, 5'd0, 5'd4, 16'd4);
    imem[9]  = enc_i(6'h2B, 5'd0, 5'd5, 16'd8);
    imem[10] = enc_i(6'h2B, 5'd0, 5'd7, 16'd12);
    imem[11] = enc_i(6'h2B, 5'd0, 5'd8, 16'd16);
    imem[12] = enc_r(6'h2A, 5'd1, 5'd2, 5'd9);
    imem[13] = enc_i(6'h2B, 5'd0, 5'd9, 16'd20);
    start_program();
    for (int k = 0; k < 14; k++) exp_pc_q.push_back(32'(k * 4));
    push_st(32'd0,  32'h0000_0002);
    push_st(32'd4,  32'hFFFF_FFF8);
    push_st(32'd8,  32'h0000_0001);
    push_st(32'd12, 32'h0000_0005);
    push_st(32'd16, 32'hFFFF_FFFD);
    push_st(32'd20, 32'h0000_0000);
    step_program(14, "arith");
  endtask

  task automatic test_memory();
    clear_imem();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'h002A);
    imem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0008);
    imem[2] = enc_i(6'h23, 5'd0, 5'd6, 16'h0008);
    imem[3] = enc_i(6'h2B, 5'd0, 5'd6, 16'h0020);
    imem[4] = enc_i(6'h08, 5'd1, 5'd1, 16'h0001);
    imem[5] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0024);
    start_program();
    for (int k = 0; k < 6; k++) exp_pc_q.push_back(32'(k * 4));
    push_st(32'h08, 32'h2A);
    push_st(32'h20, 32'h2A);
    push_st(32'h24, 32'h2B);
    step_program(6, "memory");
    total++;
    if (dmem[2] !== 32'h2A || dmem[8] !== 32'h2A || dmem[9] !== 32'h2B) begin
      bad++;
      $display("FAIL memory_contents: %h %h %h want 2a 2a 2b", dmem[2], dmem[8], dmem[9]);
    end
  endtask

  task automatic test_branch_jump();
    clear_imem();
    imem[0]  = enc_i(6'h04, 5'd0, 5'd0, 16'h0001);
    imem[1]  = enc_i(6'h08, 5'd0, 5'd10, 16'h0001);
    imem[2]  = enc_i(6'h08, 5'd0, 5'd1, 16'h0001);
    imem[3]  = enc_i(6'h04, 5'd1, 5'd0, 16'h0005);
    imem[4]  = enc_j(26'h10);
    imem[8]  = enc_i(6'h05, 5'd1, 5'd0, 16'hFFFF);
    imem[9]  = enc_i(6'h2B, 5'd0, 5'd1, 16'h003C);
    imem[16] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0030);
    imem[17] = enc_i(6'h08, 5'd0, 5'd0, 16'h0007);
    imem[18] = enc_i(6'h2B, 5'd0, 5'd0, 16'h0034);
    imem[19] = enc_i(6'h3F, 5'd1, 5'd2, 16'h1234);
    imem[20] = enc_i(6'h2B, 5'd0, 5'd2, 16'h0038);
    imem[21] = enc_j(26'h8);
    start_program();
    exp_pc_q.push_back(32'h00);
    exp_pc_q.push_back(32'h08);
    exp_pc_q.push_back(32'h0C);
    exp_pc_q.push_back(32'h10);
    exp_pc_q.push_back(32'h40);
    exp_pc_q.push_back(32'h44);
    exp_pc_q.push_back(32'h48);
    exp_pc_q.push_back(32'h4C);
    exp_pc_q.push_back(32'h50);
    exp_pc_q.push_back(32'h54);
    exp_pc_q.push_back(32'h20);
    push_st(32'h30, 32'h1);
    push_st(32'h34, 32'h0);
    push_st(32'h38, 32'h0);
`ifdef MIPS_BNE_EN
    exp_pc_q.push_back(32'h20);
    exp_pc_q.push_back(32'h20);
    step_program(13, "branch");
`else
    exp_pc_q.push_back(32'h24);
    push_st(32'h3C, 32'h1);
    step_program(12, "branch");
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    dmem_clr = 1'b1;
    clear_imem();
    test_reset();
    test_arith();
    test_memory();
    test_branch_jump();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
